// File: rtl/writeback_unit_pkg.sv
// Shared widths, opcode constants and NOP encoding for the writeback stage.
package writeback_unit_pkg;

   localparam int unsigned DataW   = 16;
   localparam int unsigned IdxW    = 3;
   localparam int unsigned NumRegs = 8;

   localparam logic [DataW-1:0] NopInstr = 16'hF000;
   localparam logic [IdxW-1:0]  PcIdx    = 3'd7;

   localparam logic [3:0] OpAdd = 4'b0000;
   localparam logic [3:0] OpAdi = 4'b0001;
   localparam logic [3:0] OpNdu = 4'b0010;
   localparam logic [3:0] OpLhi = 4'b0011;
   localparam logic [3:0] OpLw  = 4'b0100;
   localparam logic [3:0] OpSw  = 4'b0101;
   localparam logic [3:0] OpLm  = 4'b0110;
   localparam logic [3:0] OpSm  = 4'b0111;
   localparam logic [3:0] OpJal = 4'b1000;
   localparam logic [3:0] OpJlr = 4'b1001;
   localparam logic [3:0] OpBeq = 4'b1100;

endpackage

// File: rtl/regfile_8x16.sv
// 8x16 register file: two combinational read ports, one general write port and a
// dedicated R7 (PC) load port whose arbitration is done by the caller.
module regfile_8x16
   import writeback_unit_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [IdxW-1:0]  waddr,
   input  logic [DataW-1:0] wdata,
   input  logic             pc_we,
   input  logic [DataW-1:0] pc_data,
   input  logic [IdxW-1:0]  ra_sel,
   input  logic [IdxW-1:0]  rb_sel,
   output logic [DataW-1:0] ra_data,
   output logic [DataW-1:0] rb_data,
   output logic [DataW-1:0] r7_data
);

   logic [DataW-1:0] regs_q [NumRegs];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
      end else begin
         if (pc_we) regs_q[PcIdx] <= pc_data;
         if (we)    regs_q[waddr] <= wdata;
      end
   end

   assign ra_data = regs_q[ra_sel];
   assign rb_data = regs_q[rb_sel];
   assign r7_data = regs_q[PcIdx];

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: destination decode, CCR update, R7/PC arbitration, retire counter.
// Optional macro WB_BYPASS_EN forwards the in-flight write onto the read ports.
module writeback_unit
   import writeback_unit_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [DataW-1:0] IR,
   input  logic [DataW-1:0] RF_value,
   input  logic             CCRWrite,
   input  logic             C_in,
   input  logic             PC_write,
   input  logic [DataW-1:0] PC_in,
   input  logic [IdxW-1:0]  RA_sel,
   input  logic [IdxW-1:0]  RB_sel,
   output logic [DataW-1:0] RA_data,
   output logic [DataW-1:0] RB_data,
   output logic [DataW-1:0] R7_out,
   output logic             C_flag,
   output logic             Z_flag,
   output logic [DataW-1:0] retired
);

   logic [3:0]       opcode;
   logic             is_nop;
   logic             wb_we;
   logic [IdxW-1:0]  wb_idx;
   logic             pc_load;
   logic [DataW-1:0] ra_raw, rb_raw;
   logic             c_q, z_q;
   logic [DataW-1:0] retired_q;

   assign opcode = IR[15:12];
   assign is_nop = (IR == NopInstr);

   always_comb begin
      wb_we  = 1'b0;
      wb_idx = IR[11:9];
      case (opcode)
         OpAdd, OpNdu: begin
            wb_we  = 1'b1;
            wb_idx = IR[5:3];
         end
         OpAdi: begin
            wb_we  = 1'b1;
            wb_idx = IR[8:6];
         end
         OpLhi, OpLw, OpLm, OpJal, OpJlr: begin
            wb_we  = 1'b1;
            wb_idx = IR[11:9];
         end
         default: ;
      endcase
   end

   // A writeback targeting R7 beats the fetch-side PC update.
   assign pc_load = PC_write && !(wb_we && (wb_idx == PcIdx));

   regfile_8x16 u_regfile (
      .clk     (clk),
      .reset   (reset),
      .we      (wb_we),
      .waddr   (wb_idx),
      .wdata   (RF_value),
      .pc_we   (pc_load),
      .pc_data (PC_in),
      .ra_sel  (RA_sel),
      .rb_sel  (RB_sel),
      .ra_data (ra_raw),
      .rb_data (rb_raw),
      .r7_data (R7_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         c_q       <= 1'b0;
         z_q       <= 1'b0;
         retired_q <= '0;
      end else if (!is_nop) begin
         retired_q <= retired_q + 16'd1;
         if (!CCRWrite) begin
            z_q <= (RF_value == '0);
            if (opcode != OpLw) c_q <= C_in;
         end
      end
   end

   assign C_flag  = c_q;
   assign Z_flag  = z_q;
   assign retired = retired_q;

`ifdef WB_BYPASS_EN
   always_comb begin
      RA_data = ra_raw;
      RB_data = rb_raw;
      if (wb_we && (wb_idx == RA_sel))      RA_data = RF_value;
      else if (pc_load && (RA_sel == PcIdx)) RA_data = PC_in;
      if (wb_we && (wb_idx == RB_sel))      RB_data = RF_value;
      else if (pc_load && (RB_sel == PcIdx)) RB_data = PC_in;
   end
`else
   assign RA_data = ra_raw;
   assign RB_data = rb_raw;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: driver pushes expected outputs from an
// architectural model, a negedge monitor pops and compares.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] IR, RF_value, PC_in;
   logic        CCRWrite, C_in, PC_write;
   logic [2:0]  RA_sel, RB_sel;
   logic [15:0] RA_data, RB_data, R7_out, retired;
   logic        C_flag, Z_flag;

   writeback_unit dut (
      .clk      (clk),
      .reset    (reset),
      .IR       (IR),
      .RF_value (RF_value),
      .CCRWrite (CCRWrite),
      .C_in     (C_in),
      .PC_write (PC_write),
      .PC_in    (PC_in),
      .RA_sel   (RA_sel),
      .RB_sel   (RB_sel),
      .RA_data  (RA_data),
      .RB_data  (RB_data),
      .R7_out   (R7_out),
      .C_flag   (C_flag),
      .Z_flag   (Z_flag),
      .retired  (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ra, rb, r7, ret;
      logic        c, z;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Architectural state
   logic [15:0] m_regs [8];
   logic        m_c, m_z;
   logic [15:0] m_ret;

   function automatic void m_dest(input logic [15:0] ir, output logic we, output logic [2:0] idx);
      we  = 1'b1;
      idx = ir[11:9];
      case (ir[15:12])
         4'h0, 4'h2:                   idx = ir[5:3];
         4'h1:                         idx = ir[8:6];
         4'h3, 4'h4, 4'h6, 4'h8, 4'h9: idx = ir[11:9];
         default: begin we = 1'b0; idx = 3'd0; end
      endcase
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] a, input logic we, input logic [2:0] idx,
                                          input logic [15:0] rf, input logic pcw,
                                          input logic [15:0] pcin);
`ifdef WB_BYPASS_EN
      if (we && idx == a) return rf;
      if (pcw && !(we && idx == 3'd7) && a == 3'd7) return pcin;
`endif
      return m_regs[a];
   endfunction

   task automatic step(input logic rst, input logic [15:0] ir, input logic [15:0] rf,
                       input logic ccrw, input logic cin, input logic pcw,
                       input logic [15:0] pcin, input logic [2:0] ras, input logic [2:0] rbs);
      logic     we;
      logic [2:0] idx;
      exp_t     e;
      @(posedge clk);
      #1;
      reset = rst; IR = ir; RF_value = rf; CCRWrite = ccrw; C_in = cin;
      PC_write = pcw; PC_in = pcin; RA_sel = ras; RB_sel = rbs;
      m_dest(ir, we, idx);
      e.ra  = m_read(ras, we, idx, rf, pcw, pcin);
      e.rb  = m_read(rbs, we, idx, rf, pcw, pcin);
      e.r7  = m_regs[7];
      e.c   = m_c;
      e.z   = m_z;
      e.ret = m_ret;
      sb_q.push_back(e);
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 16'h0;
         m_c = 1'b0; m_z = 1'b0; m_ret = 16'h0;
      end else begin
         if (pcw) m_regs[7] = pcin;
         if (we) m_regs[idx] = rf;
         if (ir != 16'hF000) begin
            m_ret = m_ret + 16'd1;
            if (!ccrw) begin
               m_z = (rf == 16'h0);
               if (ir[15:12] != 4'h4) m_c = cin;
            end
         end
      end
   endtask

   task automatic idle(input logic [2:0] ras, input logic [2:0] rbs);
      step(1'b0, 16'hF000, 16'hDEAD, 1'b0, 1'b1, 1'b0, 16'h0, ras, rbs);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("RA_data", RA_data, e.ra);
         chk("RB_data", RB_data, e.rb);
         chk("R7_out", R7_out, e.r7);
         chk("C_flag", {15'h0, C_flag}, {15'h0, e.c});
         chk("Z_flag", {15'h0, Z_flag}, {15'h0, e.z});
         chk("retired", retired, e.ret);
      end
   end

   initial begin
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      m_c = 1'b0; m_z = 1'b0; m_ret = 16'h0;
      reset = 1'b1; IR = 16'hF000; RF_value = 16'h0; CCRWrite = 1'b1; C_in = 1'b0;
      PC_write = 1'b0; PC_in = 16'h0; RA_sel = 3'd0; RB_sel = 3'd0;
      repeat (2) @(posedge clk);

      // Reset, then ADD to R3 with carry
      step(1'b1, 16'hF000, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd0, 3'd7);
      step(1'b0, 16'h0298, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0, 3'd3, 3'd0);
      idle(3'd3, 3'd7);
      // ADI to R5 with zero result
      step(1'b0, 16'h1140, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd5, 3'd3);
      idle(3'd5, 3'd3);
      // Set C=1, then LW with zero result must leave C alone
      step(1'b0, 16'h0298, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0, 3'd3, 3'd5);
      step(1'b0, 16'h4400, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 3'd2, 3'd3);
      step(1'b0, 16'h4400, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 3'd2, 3'd3);
      idle(3'd2, 3'd3);
      // JAL to R7 beats a simultaneous PC_write
      step(1'b0, 16'h8E00, 16'h0040, 1'b1, 1'b0, 1'b1, 16'h0099, 3'd7, 3'd2);
      idle(3'd7, 3'd2);
      step(1'b0, 16'hF000, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0123, 3'd7, 3'd3);
      idle(3'd7, 3'd5);
      // NOPs and non-writing SW/BEQ
      for (int i = 0; i < 8; i++) begin
         logic [15:0] ir;
         ir = (i % 3 == 0) ? 16'hF000 : ((i % 3 == 1) ? 16'h5A5A : 16'hC6C3);
         step(1'b0, ir, 16'($urandom), 1'b1, 1'($urandom), 1'b0, 16'h0,
              3'($urandom), 3'($urandom));
      end
      // Preload R4, then reset during LW to R4
      step(1'b0, 16'h4800, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0, 3'd4, 3'd0);
      step(1'b0, 16'h4800, 16'hCAFE, 1'b1, 1'b0, 1'b0, 16'h0, 3'd4, 3'd0);
      step(1'b1, 16'h4800, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0, 3'd4, 3'd7);
      idle(3'd4, 3'd7);
      idle(3'd4, 3'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [15:0] ir;
         ir = ($urandom_range(7) == 0) ? 16'hF000 : 16'($urandom);
         step(($urandom_range(39) == 0), ir,
              ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
              3'($urandom), 3'($urandom));
      end

      // Retire counter wrap: 65535 retires to 16'hFFFF, then one more
      step(1'b1, 16'hF000, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd0, 3'd0);
      for (int i = 0; i < 65535; i++)
         step(1'b0, 16'h5000, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd0, 3'd1);
      step(1'b0, 16'hC000, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 3'd0, 3'd1);
      idle(3'd0, 3'd1);

      repeat (4) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have no parameters; widths are fixed by the shared package: data 16, register index 3, 8 registers.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 IR  in  16  instruction from the final pipeline register; 16'hF000 = NOP.
REQ-005 RF_value  in  16  result to write back.
REQ-006 CCRWrite  in  1  active-low flag-update enable; 1 = no flag update.
REQ-007 C_in  in  1  carry produced by the instruction.
REQ-008 PC_write  in  1  fetch-side R7 update strobe, active-high.
REQ-009 PC_in  in  16  next PC value for R7.
REQ-010 RA_sel / RB_sel  in  3 each  read addresses.
REQ-011 RA_data / RB_data  out  16 each  combinational read data.
REQ-012 R7_out  out  16  current R7 (PC) value.
REQ-013 C_flag / Z_flag  out  1 each  condition code register.
REQ-014 retired  out  16  count of non-NOP instructions written back.

Function
REQ-015 Opcode is IR[15:12]; RA=IR[11:9], RB=IR[8:6], RC=IR[5:3].
REQ-016 Destination decode: ADD 0000 and NDU 0010 -> RC; ADI 0001 -> RB; LHI 0011, LW 0100, LM 0110, JAL 1000, JLR 1001 -> RA; SW 0101, SM 0111, BEQ 1100, NOP and all other opcodes -> no register write.
REQ-017 A register write SHALL commit RF_value to the destination at the edge following IR presentation, one-cycle latency.
REQ-018 When CCRWrite=0 and IR is not NOP, C_flag<=C_in and Z_flag<=(RF_value==0) at the same edge; otherwise the flags hold.
REQ-019 For LW, only Z_flag updates on CCRWrite=0; C_flag holds.
REQ-020 R7 write priority: a WB write with destination 7 overrides PC_write in the same cycle; with no WB write to R7, PC_write=1 loads PC_in.
REQ-021 retired SHALL increment by 1 on every edge where IR is not NOP, wrapping 16'hFFFF -> 16'h0000.
REQ-022 Reads of RA_sel/RB_sel SHALL return stored register contents, except as modified by REQ-028.

Reset
REQ-023 When reset=1 at an edge, R0-R7, C_flag, Z_flag and retired SHALL all clear to 0.
REQ-024 Reset SHALL take priority over every simultaneous write, flag update and increment.
REQ-025 A reset asserted mid-stream SHALL discard the in-flight IR with no residual write on the next edge.

Configuration
REQ-026 The macro WB_BYPASS_EN SHALL be the only compile-time option.
REQ-027 Without WB_BYPASS_EN, read ports SHALL return pre-edge contents, so a same-cycle write is visible one cycle later.
REQ-028 With WB_BYPASS_EN, a read whose address matches the current WB destination SHALL return RF_value combinationally; R7 reads SHALL return PC_in when PC_write=1 and no WB write targets R7.

Structure
REQ-029 The shared package SHALL hold the opcode constants, the NOP encoding 16'hF000, and the data/index width constants.
REQ-030 The 8x16 register array with two read ports and one write port SHALL be a sub-module, regfile_8x16; destination decode, CCR, R7 arbitration and the counter stay in writeback_unit.

Verification
REQ-031 The bench SHALL cover these scenarios:
- Reset, then ADD IR=16'h0298 (RC=3), RF_value=16'h1234, CCRWrite=0, C_in=1 -> next cycle R3=16'h1234, C=1, Z=0, retired=1.
- ADI to RB=5 with RF_value=0, CCRWrite=0, C_in=0 -> R5=0, Z=1, C=0.
- LW to RA=2 with RF_value=0, CCRWrite=0, C_in=1, starting with C=1 -> Z=1, C stays 1.
- JAL to RA=7 with RF_value=16'h0040, same cycle PC_write=1 and PC_in=16'h0099 -> R7_out=16'h0040.
- NOP stream plus SW/BEQ -> no register or flag change; retired counts only SW/BEQ; preset retired to 16'hFFFF and retire once more -> 16'h0000.
- Reset asserted during an LW to R4 -> R4=0 and retired=0 after the edge; with WB_BYPASS_EN, RA_sel=4 during an R4 write -> RA_data=RF_value in the same cycle.
